// File: rtl/alu_issue_ctrl.sv
// Clocked initiator for the 4-phase bundled-data handshake into the combinational ALU.
// Accepts one op upstream, runs req/ack with the ALU, hands the result to writeback.
`timescale 1ns/1ps
module alu_issue_ctrl #(
    parameter int TAG_W       = 4,
    parameter int SYNC_STAGES = 2,
    parameter int TIMEOUT     = 255
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       in_op,
    input  logic [15:0]      in_a,
    input  logic [15:0]      in_b,
    input  logic [TAG_W-1:0] in_tag,
    output logic             alu_req,
    input  logic             alu_ack,
    output logic [15:0]      alu_a,
    output logic [15:0]      alu_b,
    output logic [3:0]       alu_ctrl,
    input  logic [15:0]      alu_result,
    input  logic             alu_zero,
    input  logic             alu_ovf,
    input  logic             alu_carry,
    input  logic             alu_neg,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [15:0]      out_result,
    output logic [3:0]       out_flags,
    output logic [TAG_W-1:0] out_tag,
    output logic             err_timeout,
    input  logic             err_clr
);
    typedef enum logic [1:0] {IDLE, REQ, RTZ, OUT} state_t;

    state_t                 state, state_nx;
    logic [SYNC_STAGES-1:0] ack_sync;
    logic                   ack_s;
    logic                   run;
    logic                   aborted;
    logic                   tmo_hit;
    logic                   accept, capture, tmo_req, tmo_rtz;
    logic [15:0]            cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) ack_sync <= '0;
        else        ack_sync <= {ack_sync[SYNC_STAGES-2:0], alu_ack};
    end

    assign ack_s   = ack_sync[SYNC_STAGES-1];
    assign tmo_hit = (cnt == 16'(TIMEOUT - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        in_ready = 1'b0;
        accept   = 1'b0;
        capture  = 1'b0;
        tmo_req  = 1'b0;
        tmo_rtz  = 1'b0;
        unique case (state)
            IDLE: begin
                // A lingering ack from the previous op must drain before issuing again.
                in_ready = run && !ack_s;
                if (in_valid && run && !ack_s) begin
                    accept   = 1'b1;
                    state_nx = REQ;
                end
            end
            REQ: begin
                if (ack_s) begin
                    capture  = 1'b1;
                    state_nx = RTZ;
                end else if (tmo_hit) begin
                    tmo_req  = 1'b1;
                    state_nx = RTZ;
                end
            end
            RTZ: begin
                if (!ack_s) begin
                    state_nx = aborted ? IDLE : OUT;
                end else if (tmo_hit) begin
                    tmo_rtz  = 1'b1;
                    state_nx = IDLE;
                end
            end
            OUT: begin
                if (out_ready) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run         <= 1'b0;
            alu_req     <= 1'b0;
            out_valid   <= 1'b0;
            aborted     <= 1'b0;
            err_timeout <= 1'b0;
            cnt         <= '0;
        end else begin
            run       <= 1'b1;
            alu_req   <= (state_nx == REQ);
            out_valid <= (state_nx == OUT);
            if (accept)       aborted <= 1'b0;
            else if (tmo_req) aborted <= 1'b1;
            if (tmo_req || tmo_rtz) err_timeout <= 1'b1;
            else if (err_clr)       err_timeout <= 1'b0;
            if (state_nx != state)               cnt <= '0;
            else if (state == REQ || state == RTZ) cnt <= cnt + 16'd1;
        end
    end

    // Operands only move on acceptance, keeping the bundle stable across the whole handshake.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_a      <= '0;
            alu_b      <= '0;
            alu_ctrl   <= '0;
            out_tag    <= '0;
            out_result <= '0;
            out_flags  <= '0;
        end else begin
            if (accept) begin
                alu_a    <= in_a;
                alu_b    <= in_b;
                alu_ctrl <= in_op;
                out_tag  <= in_tag;
            end
            if (capture) begin
                out_result <= alu_result;
                out_flags  <= {alu_neg, alu_zero, alu_carry, alu_ovf};
            end
        end
    end
endmodule
